// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, frame width
// and the default abort limit.
package uart_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    SEND = ST_SEND,
    DONE = ST_DONE
  } arb_state_e;

  localparam int FRAME_W = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle around the UART transmit arbiter.
// The master view belongs to the arbiter and the slave view to its environment.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   grant;
  logic                 done;
  logic                 frame_err;
  logic                 timeout_err;
  logic                 ctrl_busy;
  logic                 tx_enable;
  logic                 load;
  logic [7:0]           data_in;
  logic                 tx_busy;
  logic                 tx_error;

  modport master (
    input  req, req_data, tx_busy, tx_error,
    output grant, done, frame_err, timeout_err, ctrl_busy, tx_enable, load, data_in
  );

  modport slave (
    output req, req_data, tx_busy, tx_error,
    input  grant, done, frame_err, timeout_err, ctrl_busy, tx_enable, load, data_in
  );

endinterface

// File: rtl/uart_tx_arbiter_sync2.sv
// Two-flop synchronizer of configurable width for status bits coming from the
// transmitter clock domain.
module uart_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources;
// sequences a single frame per grant using the synchronized tx_busy handshake.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic               clk,
  input logic               ctrl_reset,
  uart_tx_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Rotate so the slot after the previous winner sits at bit 0, pick the
  // lowest set bit, then map the offset back to an absolute index.
  function automatic logic [IDX_W-1:0] rrPick(input logic [NUM_REQ-1:0] reqVec,
                                               input logic [IDX_W-1:0]   lastIdx);
    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;
    int                   start;
    int                   offset;
    start   = (int'(lastIdx) + 1) % NUM_REQ;
    doubled = {reqVec, reqVec};
    rotated = doubled[start +: NUM_REQ];
    offset  = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) offset = i;
    end
    return IDX_W'((start + offset) % NUM_REQ);
  endfunction

  arb_state_e         state_q;
  logic [IDX_W-1:0]   last_q;
  logic [IDX_W-1:0]   winIdx_q;
  logic [CNT_W-1:0]   timeoutCnt_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [7:0]         dataIn_q;
  logic               txEnable_q;
  logic               load_q;
  logic               done_q;
  logic               frameErr_q;
  logic               timeoutErr_q;
  logic               ctrlBusy_q;

  logic [IDX_W-1:0]   winIdx_d;
  logic [7:0]         winByte_d;
  logic [1:0]         syncOut;
  logic               busyS;
  logic               errS;

  uart_sync2 #(.WIDTH(2)) u_sync (
    .clk (clk),
    .rst (ctrl_reset),
    .d_i ({bus.tx_error, bus.tx_busy}),
    .q_o (syncOut)
  );

  assign busyS     = syncOut[0];
  assign errS      = syncOut[1];
  assign winIdx_d  = rrPick(bus.req, last_q);
  assign winByte_d = bus.req_data[int'(winIdx_d)*FRAME_W +: FRAME_W];

  // All outputs are registered here; done/frame_err/timeout_err default low
  // each cycle so they only ever pulse for one clock.
  always_ff @(posedge clk) begin
    if (ctrl_reset) begin
      state_q      <= IDLE;
      last_q       <= IDX_W'(NUM_REQ - 1);
      winIdx_q     <= '0;
      timeoutCnt_q <= '0;
      grant_q      <= '0;
      dataIn_q     <= '0;
      txEnable_q   <= 1'b0;
      load_q       <= 1'b0;
      done_q       <= 1'b0;
      frameErr_q   <= 1'b0;
      timeoutErr_q <= 1'b0;
      ctrlBusy_q   <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      frameErr_q   <= 1'b0;
      timeoutErr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|bus.req && !busyS) begin
            state_q      <= LOAD;
            winIdx_q     <= winIdx_d;
            grant_q      <= NUM_REQ'(1) << winIdx_d;
            dataIn_q     <= winByte_d;
            txEnable_q   <= 1'b1;
            load_q       <= 1'b1;
            ctrlBusy_q   <= 1'b1;
            timeoutCnt_q <= '0;
          end
        end
        LOAD, SEND: begin
          if (timeoutCnt_q == CNT_LAST) begin
            state_q      <= IDLE;
            last_q       <= winIdx_q;
            grant_q      <= '0;
            txEnable_q   <= 1'b0;
            load_q       <= 1'b0;
            ctrlBusy_q   <= 1'b0;
            timeoutErr_q <= 1'b1;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + 1'b1;
            if (state_q == LOAD && busyS) begin
              state_q <= SEND;
              load_q  <= 1'b0;
            end else if (state_q == SEND && !busyS) begin
              state_q    <= DONE;
              txEnable_q <= 1'b0;
              done_q     <= 1'b1;
              frameErr_q <= errS;
            end
          end
        end
        DONE: begin
          state_q    <= IDLE;
          last_q     <= winIdx_q;
          grant_q    <= '0;
          ctrlBusy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.frame_err   = frameErr_q;
  assign bus.timeout_err = timeoutErr_q;
  assign bus.ctrl_busy   = ctrlBusy_q;
  assign bus.tx_enable   = txEnable_q;
  assign bus.load        = load_q;
  assign bus.data_in     = dataIn_q;

endmodule
